// File: rtl/regfile_pkg.sv
// regfile_pkg: shared definitions for the multi-port register file.
//   calc_depth : number of entries for a given address width
//   ZERO_REG   : index of the hardwired-zero register
//   wr_sel     : resolves two write hits into a one-hot select, wr1 over wr0
package regfile_pkg;

  localparam int ZERO_REG = 0;

  function automatic int calc_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

  // Returns {take_wr1, take_wr0}; at most one bit is set.
  // Used by storage and by the read bypass, so both resolve collisions identically.
  function automatic logic [1:0] wr_sel(input logic hit0, input logic hit1);
    return {hit1, hit0 & ~hit1};
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// regfile_rd_port: one combinational read port.
//   rd_addr            : register to read
//   rf, busy_vec       : full storage image (entry 0 is zero) and busy bits
//   wrN_vld/addr/data  : this cycle's qualified writes (for bypass)
//   rd_data, rd_busy   : read result and busy flag of the addressed register
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int BYPASS = 1,
  localparam int DEPTH = calc_depth(ADDR_W)
) (
  input  logic [ADDR_W-1:0]             rd_addr,
  input  logic [DEPTH-1:0][DATA_W-1:0]  rf,
  input  logic [DEPTH-1:0]              busy_vec,
  input  logic                          wr0_vld,
  input  logic [ADDR_W-1:0]             wr0_addr,
  input  logic [DATA_W-1:0]             wr0_data,
  input  logic                          wr1_vld,
  input  logic [ADDR_W-1:0]             wr1_addr,
  input  logic [DATA_W-1:0]             wr1_data,
  output logic [DATA_W-1:0]             rd_data,
  output logic                          rd_busy
);

  localparam logic BYP = (BYPASS != 0);

  logic       hit0, hit1;
  logic [1:0] sel;

  // wrN_vld already excludes address 0, so r0 never bypasses.
  assign hit0 = BYP && wr0_vld && (wr0_addr == rd_addr);
  assign hit1 = BYP && wr1_vld && (wr1_addr == rd_addr);
  assign sel  = wr_sel(hit0, hit1);

  assign rd_data = sel[1] ? wr1_data :
                   sel[0] ? wr0_data : rf[rd_addr];

  // A write landing this cycle retires the pending writeback early.
  assign rd_busy = busy_vec[rd_addr] & ~(hit0 | hit1);

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised register file, NUM_RD read ports, two prioritised
// write ports, optional write-to-read bypass and a per-register busy scoreboard.
//   CLK100MHZ, reset         : clock, async active-high reset
//   rd_addr/rd_data/rd_busy  : NUM_RD packed combinational read ports
//   wr0_*, wr1_*             : write ports, wr1 wins on same address
//   rsv_en/rsv_addr          : mark a register busy for a future write
//   busy_vec                 : registered busy bits, bit 0 always 0
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int NUM_RD = 2,
  parameter int BYPASS = 1,
  localparam int DEPTH = calc_depth(ADDR_W)
) (
  input  logic                     CLK100MHZ,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr0_en,
  input  logic [ADDR_W-1:0]        wr0_addr,
  input  logic [DATA_W-1:0]        wr0_data,
  input  logic                     wr1_en,
  input  logic [ADDR_W-1:0]        wr1_addr,
  input  logic [DATA_W-1:0]        wr1_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic [DEPTH-1:0]         busy_vec
);

  localparam logic [ADDR_W-1:0] ZADDR = ADDR_W'(ZERO_REG);

  logic [DEPTH-1:1][DATA_W-1:0] mem_q;
  logic [DEPTH-1:1]             busy_q;
  logic [DEPTH-1:0][DATA_W-1:0] rf;

  logic                         wr0_vld, wr1_vld, rsv_vld;
  logic [DEPTH-1:1][1:0]        wsel;
  logic [DEPTH-1:1]             rsv_hit;

  // Reset gating here also suppresses bypass, so reads are 0 while reset is high.
  assign wr0_vld = wr0_en && (wr0_addr != ZADDR) && !reset;
  assign wr1_vld = wr1_en && (wr1_addr != ZADDR) && !reset;
  assign rsv_vld = rsv_en && (rsv_addr != ZADDR) && !reset;

  always_comb begin
    wsel    = '0;
    rsv_hit = '0;
    for (int i = 1; i < DEPTH; i++) begin
      wsel[i]    = wr_sel(wr0_vld && (wr0_addr == ADDR_W'(i)),
                          wr1_vld && (wr1_addr == ADDR_W'(i)));
      rsv_hit[i] = rsv_vld && (rsv_addr == ADDR_W'(i));
    end
  end

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      mem_q  <= '0;
      busy_q <= '0;
    end else begin
      for (int i = 1; i < DEPTH; i++) begin
        if (wsel[i][1])      mem_q[i] <= wr1_data;
        else if (wsel[i][0]) mem_q[i] <= wr0_data;
        // Reservation beats a same-cycle write: the new producer is still pending.
        if (rsv_hit[i])      busy_q[i] <= 1'b1;
        else if (|wsel[i])   busy_q[i] <= 1'b0;
      end
    end
  end

  assign rf       = {mem_q, {DATA_W{1'b0}}};
  assign busy_vec = {busy_q, 1'b0};

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    regfile_rd_port #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .BYPASS (BYPASS)
    ) u_rd (
      .rd_addr  (rd_addr[k*ADDR_W +: ADDR_W]),
      .rf       (rf),
      .busy_vec (busy_vec),
      .wr0_vld  (wr0_vld),
      .wr0_addr (wr0_addr),
      .wr0_data (wr0_data),
      .wr1_vld  (wr1_vld),
      .wr1_addr (wr1_addr),
      .wr1_data (wr1_data),
      .rd_data  (rd_data[k*DATA_W +: DATA_W]),
      .rd_busy  (rd_busy[k])
    );
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file, the next generation of the team's two-read/one-write register file. It provides NUM_RD read ports, two prioritised write ports and optional same-cycle write-to-read bypass. It also keeps a per-register busy scoreboard so the pipelined CPU datapath can detect pending writebacks. Register 0 is hardwired to zero.

## Interface
- ADDR_W, default 5: address width; DEPTH = 2**ADDR_W entries, entry 0 is constant zero.
- DATA_W, default 32: data width.
- NUM_RD, default 2, range 1..4: number of independent read ports.
- BYPASS, default 1: 1 means reads see same-cycle write data; 0 means reads see stored contents only.

Ports:
- CLK100MHZ  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high; clears every entry and every busy bit.
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  read data, combinational, port k uses [k*DATA_W +: DATA_W].
- rd_busy  out  NUM_RD  busy flag of the addressed register, combinational.
- wr0_en, wr1_en  in  1 each  write enables.
- wr0_addr, wr1_addr  in  ADDR_W each  write addresses.
- wr0_data, wr1_data  in  DATA_W each  write data.
- rsv_en  in  1  reserve a register (mark busy) for a future write.
- rsv_addr  in  ADDR_W  register to reserve.
- busy_vec  out  DEPTH  registered busy bits; bit 0 is always 0.

## Operation
- Storage is entries 1..DEPTH-1 only. A read of address 0 returns 0 with busy 0, regardless of writes.
- Writes: on each edge, wrN_en with a nonzero address stores wrN_data. If both ports target the same nonzero address, wr1 wins. A write to address 0 is dropped.
- Reads are combinational, per port k:
  - If BYPASS=1 and the read address matches a valid write this cycle, return that write's data; wr1 has priority over wr0.
  - Otherwise return the stored entry.
- Scoreboard:
  - A valid write (en=1, address nonzero) clears busy[addr] at the edge.
  - rsv_en with a nonzero address sets busy[rsv_addr] at the edge.
  - If a reservation and a write target the same address in the same cycle, the reservation wins and busy stays 1.
  - A reservation of address 0 is ignored.
- rd_busy[k]:
  - BYPASS=1: reports busy_vec[rd_addr_k], forced to 0 when a same-cycle valid write targets that address.
  - BYPASS=0: reports busy_vec[rd_addr_k] unmodified.
- Reset: asserting reset at any time, including mid-write, clears all entries to 0 and busy_vec to 0 immediately. Writes and reservations present while reset is high are discarded.

## Timing
- Write latency is 1 edge: data written at edge t is readable from stored state after t. With BYPASS=1 it is also visible combinationally in the cycle before edge t.
- Read latency is 0 cycles (combinational from rd_addr, storage and write ports).
- busy_vec is registered and changes only at edges or on reset assertion.
- Reset values: rd_data = 0 for every address; rd_busy = 0; busy_vec = 0.
- No handshake and no stall; every request is accepted every cycle.

## Structure
- Shared package regfile_pkg holds:
  - the function computing DEPTH from ADDR_W;
  - the constant ZERO_REG = 0;
  - the write-priority resolution function (wr1 over wr0) reused by storage and bypass.
- Sub-module regfile_rd_port: one read mux with bypass and busy masking, instantiated NUM_RD times in a generate loop.
- Storage and the scoreboard live in the top module.

## Test plan
- Reset with storage preloaded: assert reset mid-cycle after writing 0xDEADBEEF to r5. Every read returns 0 and busy_vec = 0 before the next edge; a write attempted during reset is lost.
- Dual-write collision: wr0 (r7, 0x11) and wr1 (r7, 0x22) in the same cycle. After the edge r7 reads 0x22. With BYPASS=1 a same-cycle read of r7 returns 0x22.
- Zero register: write 0xFFFFFFFF to r0 and reserve r0. r0 reads 0, busy_vec[0] = 0.
- Bypass modes: with BYPASS=1, a read of r3 in the same cycle as writing 0xA5A5A5A5 returns 0xA5A5A5A5. With BYPASS=0 it returns the old value and returns 0xA5A5A5A5 from the next cycle.
- Scoreboard: reserve r9 and observe busy_vec[9] = 1 one edge later. Write r9 and busy clears at that edge; with BYPASS=1, rd_busy for r9 is already 0 during the write cycle. A simultaneous reserve and write of r9 leaves busy = 1.
- All NUM_RD=4 ports reading distinct addresses r1..r4 holding 1..4 return 1..4 concurrently.
